pwm_peripheral: RTL and testbench
=================================

Name: pwm_peripheral

Overview:
- Consumes the five 8-bit control registers written over SPI by the upstream SPI peripheral, and drives 16 output pins.
- Each pin is statically off, statically on, or carries a shared 8-bit PWM waveform.
- Timebase: clk divided by a prescaler, then an 8-bit period counter. With clk = 10 MHz and PRESCALE = 13, the period rate is about 3.0 kHz.
- Duty is double-buffered so a period is never torn by an SPI write.

Parameters:
- PRESCALE, 13, clk cycles per PWM counter step (integer, >= 1)
- CH, 16, number of output channels (fixed by register map; not to be overridden)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en_reg_out_7_0  input  8  output enable, channels 7..0 (SPI addr 0x00)
- en_reg_out_15_8  input  8  output enable, channels 15..8 (addr 0x01)
- en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0 (addr 0x02)
- en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8 (addr 0x03)
- pwm_duty_cycle  input  8  duty value, 0..255 (addr 0x04)
- out  output  16  channel outputs, registered
- period_start  output  1  one-clk pulse on the first clk of each PWM period

Behaviour:
- Reset is asynchronous, active-high. While rst is high:
  - out = 16'h0000, period_start = 0
  - prescale_cnt = 0, pwm_cnt = 0, duty_shadow = 8'h00
- Register inputs are treated as synchronous to clk. They are stable, already-synced register outputs, so no synchroniser is required.
- Prescaler:
  - prescale_cnt counts 0..PRESCALE-1, then wraps to 0.
  - tick is asserted when prescale_cnt == PRESCALE-1.
  - With PRESCALE = 1, tick is asserted every cycle.
- Period counter:
  - pwm_cnt increments by 1 on tick and wraps from 255 to 0 (modulo 256).
  - One PWM period = 256 * PRESCALE clk cycles.
- Duty shadow:
  - duty_shadow <= pwm_duty_cycle on the clk edge where tick is high and pwm_cnt == 255, i.e. the same edge at which pwm_cnt wraps to 0.
  - A duty write mid-period has no effect until the next period boundary.
  - First period after reset uses duty 0.
- period_start:
  - Registered pulse, high for exactly one clk on the cycle following the wrap edge, when pwm_cnt == 0 first becomes visible.
  - Not asserted for the initial pwm_cnt == 0 immediately after reset release.
- PWM level, evaluated from the current pwm_cnt and duty_shadow:
  - duty_shadow == 0 -> 0
  - duty_shadow == 255 -> 1 (constant high, no glitch at wrap)
  - otherwise -> (pwm_cnt < duty_shadow)
  - High time is therefore duty_shadow * PRESCALE clk cycles per period.
- Per channel i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - en_out[i] = 0 -> out[i] next = 0 (en_out takes priority)
  - en_out[i] = 1, en_pwm[i] = 0 -> 1
  - en_out[i] = 1, en_pwm[i] = 1 -> PWM level
- Latency and timing:
  - out is registered: 1 clk latency from any input or counter change.
  - Enable and mode changes are not shadowed; they take effect 1 clk after the input changes.
  - All PWM channels share one counter and are phase-aligned.
- Reset asserted mid-period immediately forces all state to the reset values. After release, counting restarts from 0 with duty_shadow = 0.

Decomposition:
- Shared package pwm_pkg:
  - PWM_BITS = 8, NUM_CH = 16
  - Register addresses: ADDR_EN_OUT_LO = 7'h00, ADDR_EN_OUT_HI = 7'h01, ADDR_EN_PWM_LO = 7'h02, ADDR_EN_PWM_HI = 7'h03, ADDR_DUTY = 7'h04, MAX_ADDR = 7'h04
  - The SPI peripheral uses the same package for address range checks.
- One sub-module: pwm_timebase (prescaler + pwm_cnt + tick/wrap/period_start generation).
- Channel muxing and duty shadow live in pwm_peripheral.

Test Plan:
1. Reset, then en_out = 16'hFFFF, en_pwm = 0 -> out = 16'hFFFF one clk later. Assert rst asynchronously mid-cycle -> out = 0 immediately.
2. PRESCALE = 1, en_out = en_pwm = 16'h0001, duty = 8'h80, wait one period boundary -> out[0] high exactly 128 of every 256 clk, other bits 0, period_start every 256 clk.
3. Same setup with duty = 8'h00 -> out[0] constantly 0. Then duty = 8'hFF -> out[0] constantly 1 after the next boundary, with no 1-clk low at the wrap.
4. PRESCALE = 13, duty = 8'h40 -> period = 3328 clk, high = 832 clk. Change duty to 8'hC0 at pwm_cnt = 10 -> current period still 832 clk high, next period 2496 clk high.
5. Mixed modes: en_out = 16'hF0F0, en_pwm = 16'hFF00, duty = 8'h80 -> out[15:12] toggling, out[7:4] = 1, all other bits 0. Clear en_out[15] mid-period -> out[15] = 0 one clk later.
6. Release reset with duty preset to 8'h80 -> out stays 0 for the first period, PWM begins after the first wrap, and the first period_start is seen at clk 256*PRESCALE.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: constants shared by the PWM block and the SPI register front end.
//   PWM_BITS      - width of the period counter and duty register
//   NUM_CH        - number of output channels
//   ADDR_*        - SPI register addresses; MAX_ADDR bounds the valid range
//   pwm_level()   - PWM compare with pinned behaviour at duty 0 and 255
package pwm_pkg;

    localparam int unsigned PWM_BITS = 8;
    localparam int unsigned NUM_CH   = 16;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;
    localparam logic [6:0] MAX_ADDR       = 7'h04;

    // Full-scale duty is held high through the wrap instead of dropping for count 255.
    function automatic logic pwm_level(input logic [PWM_BITS-1:0] cnt,
                                       input logic [PWM_BITS-1:0] duty);
        if (duty == '0) begin
            return 1'b0;
        end else if (duty == '1) begin
            return 1'b1;
        end else begin
            return cnt < duty;
        end
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus 8-bit period counter shared by all channels.
//   i_clk, i_rst     - clock, asynchronous active-high reset
//   o_pwm_cnt        - current position inside the PWM period
//   o_wrap           - high on the cycle whose edge takes pwm_cnt from 255 to 0
//   o_period_start   - registered one-clk pulse when pwm_cnt == 0 first becomes visible
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 13
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic [PWM_BITS-1:0] o_pwm_cnt,
    output logic                o_wrap,
    output logic                o_period_start
);

    // Keep at least one bit so PRESCALE = 1 still elaborates.
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     r_prescale_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_period_start;
    logic                w_tick;
    logic                w_wrap;

    assign w_tick = (r_prescale_cnt == PS_LAST);
    assign w_wrap = w_tick && (r_pwm_cnt == '1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prescale_cnt <= '0;
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_prescale_cnt <= w_tick ? '0 : r_prescale_cnt + 1'b1;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
            // Only a real wrap pulses, so the count of 0 right after reset does not.
            r_period_start <= w_wrap;
        end
    end

    assign o_pwm_cnt      = r_pwm_cnt;
    assign o_wrap         = w_wrap;
    assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel off/on/PWM output stage driven by the SPI register bank.
//   clk, rst             - clock, asynchronous active-high reset
//   en_reg_out_7_0/15_8  - per-channel output enable (enable wins over mode)
//   en_reg_pwm_7_0/15_8  - per-channel mode: 0 = static high, 1 = shared PWM
//   pwm_duty_cycle       - duty, loaded into a shadow register at each period wrap
//   out                  - registered channel outputs
//   period_start         - one-clk pulse at the start of each PWM period
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 13,
    parameter int unsigned CH       = NUM_CH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    en_reg_out_7_0,
    input  logic [7:0]    en_reg_out_15_8,
    input  logic [7:0]    en_reg_pwm_7_0,
    input  logic [7:0]    en_reg_pwm_15_8,
    input  logic [7:0]    pwm_duty_cycle,
    output logic [CH-1:0] out,
    output logic          period_start
);

    logic [PWM_BITS-1:0] w_pwm_cnt;
    logic                w_wrap;
    logic [PWM_BITS-1:0] r_duty_shadow;
    logic [CH-1:0]       r_out;
    logic [CH-1:0]       w_en_out;
    logic [CH-1:0]       w_en_pwm;
    logic                w_level;

    pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_pwm_cnt      (w_pwm_cnt),
        .o_wrap         (w_wrap),
        .o_period_start (period_start)
    );

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_level  = pwm_level(w_pwm_cnt, r_duty_shadow);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_shadow <= '0;
            r_out         <= '0;
        end else begin
            // New duty only lands on the wrap edge so a period is never torn.
            if (w_wrap) begin
                r_duty_shadow <= pwm_duty_cycle;
            end
            r_out <= w_en_out & (~w_en_pwm | {CH{w_level}});
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed self-checking bench. Two instances share stimulus:
// u_dut1 uses PRESCALE = 1 (256-clk period), u_dut13 uses PRESCALE = 13 (3328-clk period).
module tb_pwm_peripheral;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  eo_lo = '0, eo_hi = '0, ep_lo = '0, ep_hi = '0, duty = '0;
    logic [15:0] out1, out13;
    logic        ps1, ps13;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.PRESCALE(1)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out1),
        .period_start    (ps1)
    );

    pwm_peripheral #(.PRESCALE(13)) u_dut13 (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out13),
        .period_start    (ps13)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        eo_lo = eo[7:0];
        eo_hi = eo[15:8];
        ep_lo = ep[7:0];
        ep_hi = ep[15:8];
        duty  = d;
    endtask

    // After this returns, the next posedge is the first counted edge after release.
    task automatic do_reset(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        rst = 1'b1;
        set_regs(eo, ep, d);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic sample(input int which, output logic [15:0] o, output logic p);
        if (which == 1) begin
            o = out1;
            p = ps1;
        end else begin
            o = out13;
            p = ps13;
        end
    endtask

    // Steps until period_start; returns edges taken and cycles with out[0] high.
    task automatic wait_ps(input int which, input int bound, output int n, output int hi);
        logic [15:0] o;
        logic        p;
        n  = 0;
        hi = 0;
        do begin
            step();
            n++;
            sample(which, o, p);
            if (o[0]) hi++;
        end while (!p && n < bound);
    endtask

    task automatic measure(input int which, input int n, input int change_at,
                           input logic [7:0] new_duty,
                           output int hi, output int ps, output int stray);
        logic [15:0] o;
        logic        p;
        hi    = 0;
        ps    = 0;
        stray = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            sample(which, o, p);
            if (o[0]) hi++;
            if (p) ps++;
            if (o[15:1] != 15'h0) stray++;
            if (i == change_at) duty = new_duty;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_regs(16'h0000, 16'h0000, 8'h00);
        step();
        checks++; if (out1 !== 16'h0000) begin failures++;
            $display("FAIL reset_out1: got %h expected 0000", out1); end
        checks++; if (ps1 !== 1'b0) begin failures++;
            $display("FAIL reset_ps1: got %b expected 0", ps1); end
        checks++; if (out13 !== 16'h0000) begin failures++;
            $display("FAIL reset_out13: got %h expected 0000", out13); end
        rst = 1'b0;
        set_regs(16'hFFFF, 16'h0000, 8'h00);
        #1;
        checks++; if (out1 !== 16'h0000) begin failures++;
            $display("FAIL static_before_edge: got %h expected 0000", out1); end
        step();
        checks++; if (out1 !== 16'hFFFF) begin failures++;
            $display("FAIL static_on_out1: got %h expected ffff", out1); end
        checks++; if (out13 !== 16'hFFFF) begin failures++;
            $display("FAIL static_on_out13: got %h expected ffff", out13); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out1 !== 16'h0000) begin failures++;
            $display("FAIL async_reset_out1: got %h expected 0000", out1); end
        checks++; if (out13 !== 16'h0000) begin failures++;
            $display("FAIL async_reset_out13: got %h expected 0000", out13); end
    endtask

    task automatic test_pwm_basic();
        int n, hi, ps, stray;
        do_reset(16'h0001, 16'h0001, 8'h80);
        wait_ps(1, 600, n, hi);
        checks++; if (n != 256) begin failures++;
            $display("FAIL first_ps_p1: got %0d clk expected 256", n); end
        checks++; if (hi != 0) begin failures++;
            $display("FAIL first_period_low_p1: got %0d high expected 0", hi); end
        measure(1, 256, 0, 8'h00, hi, ps, stray);
        checks++; if (hi != 128) begin failures++;
            $display("FAIL duty80_high: got %0d expected 128", hi); end
        checks++; if (ps != 1) begin failures++;
            $display("FAIL duty80_ps: got %0d expected 1", ps); end
        checks++; if (stray != 0) begin failures++;
            $display("FAIL duty80_other_bits: got %0d expected 0", stray); end
    endtask

    task automatic test_duty_extremes();
        int hi, ps, stray;
        duty = 8'h00;
        measure(1, 256, 0, 8'h00, hi, ps, stray);
        checks++; if (hi != 128) begin failures++;
            $display("FAIL old_duty_kept: got %0d expected 128", hi); end
        measure(1, 256, 0, 8'h00, hi, ps, stray);
        checks++; if (hi != 0) begin failures++;
            $display("FAIL duty00_high: got %0d expected 0", hi); end
        duty = 8'hFF;
        measure(1, 256, 0, 8'h00, hi, ps, stray);
        checks++; if (hi != 0) begin failures++;
            $display("FAIL dutyff_before_boundary: got %0d expected 0", hi); end
        measure(1, 512, 0, 8'h00, hi, ps, stray);
        checks++; if (hi != 512) begin failures++;
            $display("FAIL dutyff_no_glitch: got %0d expected 512", hi); end
        checks++; if (ps != 2) begin failures++;
            $display("FAIL dutyff_ps: got %0d expected 2", ps); end
    endtask

    task automatic test_prescale13();
        int n, hi, ps, stray;
        do_reset(16'h0001, 16'h0001, 8'h40);
        wait_ps(13, 4000, n, hi);
        checks++; if (n != 3328) begin failures++;
            $display("FAIL first_ps_p13: got %0d clk expected 3328", n); end
        checks++; if (hi != 0) begin failures++;
            $display("FAIL first_period_low_p13: got %0d high expected 0", hi); end
        measure(13, 3328, 0, 8'h00, hi, ps, stray);
        checks++; if (hi != 832) begin failures++;
            $display("FAIL duty40_high: got %0d expected 832", hi); end
        checks++; if (ps != 1) begin failures++;
            $display("FAIL duty40_ps: got %0d expected 1", ps); end
        // Edge 130 into the period leaves pwm_cnt at 10.
        measure(13, 3328, 130, 8'hC0, hi, ps, stray);
        checks++; if (hi != 832) begin failures++;
            $display("FAIL midperiod_write_shadowed: got %0d expected 832", hi); end
        measure(13, 3328, 0, 8'h00, hi, ps, stray);
        checks++; if (hi != 2496) begin failures++;
            $display("FAIL dutyc0_high: got %0d expected 2496", hi); end
        checks++; if (ps != 1) begin failures++;
            $display("FAIL dutyc0_ps: got %0d expected 1", ps); end
    endtask

    task automatic test_mixed();
        int n, hi, bad;
        set_regs(16'hF0F0, 16'hFF00, 8'h80);
        wait_ps(1, 300, n, hi);
        checks++; if (ps1 !== 1'b1) begin failures++;
            $display("FAIL mixed_sync_timeout: got ps=%b expected 1", ps1); end
        hi  = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (out1[15:12] == 4'hF) hi++;
            if (out1[11:8] != 4'h0 || out1[3:0] != 4'h0 || out1[7:4] != 4'hF ||
                !(out1[15:12] == 4'h0 || out1[15:12] == 4'hF)) bad++;
        end
        checks++; if (hi != 128) begin failures++;
            $display("FAIL mixed_pwm_high: got %0d expected 128", hi); end
        checks++; if (bad != 0) begin failures++;
            $display("FAIL mixed_static_bits: got %0d bad cycles expected 0", bad); end
        for (int i = 0; i < 10; i++) step();
        checks++; if (out1[15:12] !== 4'hF) begin failures++;
            $display("FAIL mixed_pwm_phase: got %h expected f", out1[15:12]); end
        eo_hi = 8'h70;
        #1;
        checks++; if (out1[15] !== 1'b1) begin failures++;
            $display("FAIL disable_registered: got %b expected 1", out1[15]); end
        step();
        checks++; if (out1[15:12] !== 4'h7) begin failures++;
            $display("FAIL disable_ch15: got %h expected 7", out1[15:12]); end
        checks++; if (out1[7:4] !== 4'hF) begin failures++;
            $display("FAIL static_after_disable: got %h expected f", out1[7:4]); end
    endtask

    initial begin
        test_reset();
        test_pwm_basic();
        test_duty_extremes();
        test_prescale13();
        test_mixed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
